// File: rtl/mem_axi_pkg.sv
// Shared AXI field widths and the address-channel payload struct for the PS HP port arbiter.
package mem_axi_pkg;
  localparam int unsigned ID_DN_W = 6;
  localparam logic [3:0]  MEM_BASE_DEF = 4'h1;

  typedef struct packed {
    logic [31:0]        addr;
    logic [ID_DN_W-1:0] id;
    logic [7:0]         len;
    logic [2:0]         size;
    logic [1:0]         burst;
    logic [3:0]         cache;
    logic               lock;
    logic [2:0]         prot;
    logic [3:0]         qos;
  } ax_t;
endpackage

// File: rtl/mem_axi_ax_arb.sv
// One registered AR/AW slot fed by a two-way round-robin arbiter; tags id with source, remaps addr.
// Latency 1 cycle; loads when empty or draining the same cycle, and never while hold is high.
module mem_axi_ax_arb
  import mem_axi_pkg::*;
#(
  parameter int unsigned ID_W     = 5,
  parameter logic [3:0]  MEM_BASE = MEM_BASE_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic m0_vld,
  input  ax_t  m0_pay,
  output logic m0_rdy,
  input  logic m1_vld,
  input  ax_t  m1_pay,
  output logic m1_rdy,
  input  logic hold,
  output logic s_vld,
  output ax_t  s_pay,
  input  logic s_rdy
);
  ax_t  pay_q, pay_d, sel;
  logic vld_q, vld_d;
  logic last_m1_q, last_m1_d;
  logic pick_m1, load;

  always_comb begin
    pick_m1   = m1_vld && (!m0_vld || !last_m1_q);
    load      = (m0_vld || m1_vld) && (!vld_q || s_rdy) && !hold;
    sel       = pick_m1 ? m1_pay : m0_pay;
    vld_d     = vld_q && !s_rdy;
    pay_d     = pay_q;
    last_m1_d = last_m1_q;
    if (load) begin
      vld_d      = 1'b1;
      pay_d      = sel;
      pay_d.addr = {MEM_BASE, sel.addr[27:0]};
      // upstream id arrives with its top bit clear; the source tag goes there
      pay_d.id   = sel.id | (ID_DN_W'(pick_m1) << ID_W);
      last_m1_d  = pick_m1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q     <= 1'b0;
      pay_q     <= '0;
      last_m1_q <= 1'b1;
    end else begin
      vld_q     <= vld_d;
      pay_q     <= pay_d;
      last_m1_q <= last_m1_d;
    end
  end

  assign m0_rdy = load && !pick_m1;
  assign m1_rdy = load && pick_m1;
  assign s_vld  = vld_q;
  assign s_pay  = pay_q;
endmodule

// File: rtl/mem_axi_arbiter.sv
// Two AXI4 masters onto one PS HP slave port: RR on AR/AW, W steered in AW order, R/B routed by id tag.
// AR/AW 1 cycle, W/R/B combinational; W-order queue full stalls AW unless a last beat pops that cycle.
module mem_axi_arbiter
  import mem_axi_pkg::*;
#(
  parameter int unsigned ID_W     = 5,
  parameter logic [3:0]  MEM_BASE = MEM_BASE_DEF,
  parameter int unsigned WQ_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            m0_ar_valid, output logic m0_ar_ready,
  input  logic [31:0]     m0_ar_addr,  input  logic [ID_W-1:0] m0_ar_id,
  input  logic [7:0]      m0_ar_len,   input  logic [2:0] m0_ar_size,
  input  logic [1:0]      m0_ar_burst, input  logic [3:0] m0_ar_cache,
  input  logic            m0_ar_lock,  input  logic [2:0] m0_ar_prot,
  input  logic [3:0]      m0_ar_qos,
  input  logic            m1_ar_valid, output logic m1_ar_ready,
  input  logic [31:0]     m1_ar_addr,  input  logic [ID_W-1:0] m1_ar_id,
  input  logic [7:0]      m1_ar_len,   input  logic [2:0] m1_ar_size,
  input  logic [1:0]      m1_ar_burst, input  logic [3:0] m1_ar_cache,
  input  logic            m1_ar_lock,  input  logic [2:0] m1_ar_prot,
  input  logic [3:0]      m1_ar_qos,
  input  logic            m0_aw_valid, output logic m0_aw_ready,
  input  logic [31:0]     m0_aw_addr,  input  logic [ID_W-1:0] m0_aw_id,
  input  logic [7:0]      m0_aw_len,   input  logic [2:0] m0_aw_size,
  input  logic [1:0]      m0_aw_burst, input  logic [3:0] m0_aw_cache,
  input  logic            m0_aw_lock,  input  logic [2:0] m0_aw_prot,
  input  logic [3:0]      m0_aw_qos,
  input  logic            m1_aw_valid, output logic m1_aw_ready,
  input  logic [31:0]     m1_aw_addr,  input  logic [ID_W-1:0] m1_aw_id,
  input  logic [7:0]      m1_aw_len,   input  logic [2:0] m1_aw_size,
  input  logic [1:0]      m1_aw_burst, input  logic [3:0] m1_aw_cache,
  input  logic            m1_aw_lock,  input  logic [2:0] m1_aw_prot,
  input  logic [3:0]      m1_aw_qos,
  input  logic            m0_w_valid,  output logic m0_w_ready,
  input  logic [63:0]     m0_w_data,   input  logic [7:0] m0_w_strb,
  input  logic            m0_w_last,
  input  logic            m1_w_valid,  output logic m1_w_ready,
  input  logic [63:0]     m1_w_data,   input  logic [7:0] m1_w_strb,
  input  logic            m1_w_last,
  output logic            m0_r_valid,  input  logic m0_r_ready,
  output logic [ID_W-1:0] m0_r_id,     output logic [63:0] m0_r_data,
  output logic [1:0]      m0_r_resp,   output logic m0_r_last,
  output logic            m1_r_valid,  input  logic m1_r_ready,
  output logic [ID_W-1:0] m1_r_id,     output logic [63:0] m1_r_data,
  output logic [1:0]      m1_r_resp,   output logic m1_r_last,
  output logic            m0_b_valid,  input  logic m0_b_ready,
  output logic [ID_W-1:0] m0_b_id,     output logic [1:0] m0_b_resp,
  output logic            m1_b_valid,  input  logic m1_b_ready,
  output logic [ID_W-1:0] m1_b_id,     output logic [1:0] m1_b_resp,
  output logic            s_ar_valid,  input  logic s_ar_ready,
  output logic [31:0]     s_ar_addr,   output logic [ID_W:0] s_ar_id,
  output logic [7:0]      s_ar_len,    output logic [2:0] s_ar_size,
  output logic [1:0]      s_ar_burst,  output logic [3:0] s_ar_cache,
  output logic            s_ar_lock,   output logic [2:0] s_ar_prot,
  output logic [3:0]      s_ar_qos,
  output logic            s_aw_valid,  input  logic s_aw_ready,
  output logic [31:0]     s_aw_addr,   output logic [ID_W:0] s_aw_id,
  output logic [7:0]      s_aw_len,    output logic [2:0] s_aw_size,
  output logic [1:0]      s_aw_burst,  output logic [3:0] s_aw_cache,
  output logic            s_aw_lock,   output logic [2:0] s_aw_prot,
  output logic [3:0]      s_aw_qos,
  output logic            s_w_valid,   input  logic s_w_ready,
  output logic [63:0]     s_w_data,    output logic [7:0] s_w_strb,
  output logic            s_w_last,
  input  logic            s_r_valid,   output logic s_r_ready,
  input  logic [ID_W:0]   s_r_id,      input  logic [63:0] s_r_data,
  input  logic [1:0]      s_r_resp,    input  logic s_r_last,
  input  logic            s_b_valid,   output logic s_b_ready,
  input  logic [ID_W:0]   s_b_id,      input  logic [1:0] s_b_resp
);
  localparam int unsigned PW = $clog2(WQ_DEPTH);

  ax_t  m0_ar, m1_ar, m0_aw, m1_aw, s_ar, s_aw;
  logic ar_m0_rdy, ar_m1_rdy, aw_m0_rdy, aw_m1_rdy;
  logic aw_push, aw_hold, w_pop, wq_head, wq_head_vld, wq_full;
  logic [WQ_DEPTH-1:0] wq_q, wq_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]         wq_cnt_q, wq_cnt_d;

  assign m0_ar = '{addr: m0_ar_addr, id: {1'b0, m0_ar_id}, len: m0_ar_len, size: m0_ar_size,
                   burst: m0_ar_burst, cache: m0_ar_cache, lock: m0_ar_lock, prot: m0_ar_prot, qos: m0_ar_qos};
  assign m1_ar = '{addr: m1_ar_addr, id: {1'b0, m1_ar_id}, len: m1_ar_len, size: m1_ar_size,
                   burst: m1_ar_burst, cache: m1_ar_cache, lock: m1_ar_lock, prot: m1_ar_prot, qos: m1_ar_qos};
  assign m0_aw = '{addr: m0_aw_addr, id: {1'b0, m0_aw_id}, len: m0_aw_len, size: m0_aw_size,
                   burst: m0_aw_burst, cache: m0_aw_cache, lock: m0_aw_lock, prot: m0_aw_prot, qos: m0_aw_qos};
  assign m1_aw = '{addr: m1_aw_addr, id: {1'b0, m1_aw_id}, len: m1_aw_len, size: m1_aw_size,
                   burst: m1_aw_burst, cache: m1_aw_cache, lock: m1_aw_lock, prot: m1_aw_prot, qos: m1_aw_qos};

  mem_axi_ax_arb #(.ID_W(ID_W), .MEM_BASE(MEM_BASE)) u_ar_arb (
    .clock(clock), .reset_n(reset_n),
    .m0_vld(m0_ar_valid), .m0_pay(m0_ar), .m0_rdy(ar_m0_rdy),
    .m1_vld(m1_ar_valid), .m1_pay(m1_ar), .m1_rdy(ar_m1_rdy),
    .hold(1'b0), .s_vld(s_ar_valid), .s_pay(s_ar), .s_rdy(s_ar_ready)
  );

  mem_axi_ax_arb #(.ID_W(ID_W), .MEM_BASE(MEM_BASE)) u_aw_arb (
    .clock(clock), .reset_n(reset_n),
    .m0_vld(m0_aw_valid), .m0_pay(m0_aw), .m0_rdy(aw_m0_rdy),
    .m1_vld(m1_aw_valid), .m1_pay(m1_aw), .m1_rdy(aw_m1_rdy),
    .hold(aw_hold), .s_vld(s_aw_valid), .s_pay(s_aw), .s_rdy(s_aw_ready)
  );

  // grants are masked here so upstream sees no ready while reset is held
  assign m0_ar_ready = reset_n && ar_m0_rdy;
  assign m1_ar_ready = reset_n && ar_m1_rdy;
  assign m0_aw_ready = reset_n && aw_m0_rdy;
  assign m1_aw_ready = reset_n && aw_m1_rdy;

  assign {s_ar_addr, s_ar_id, s_ar_len, s_ar_size, s_ar_burst, s_ar_cache, s_ar_lock, s_ar_prot, s_ar_qos} = s_ar;
  assign {s_aw_addr, s_aw_id, s_aw_len, s_aw_size, s_aw_burst, s_aw_cache, s_aw_lock, s_aw_prot, s_aw_qos} = s_aw;

  assign wq_head     = wq_q[rd_ptr_q];
  assign wq_head_vld = (wq_cnt_q != '0);
  assign wq_full     = (wq_cnt_q == (PW+1)'(WQ_DEPTH));
  assign s_w_valid   = wq_head_vld && (wq_head ? m1_w_valid : m0_w_valid);
  assign s_w_data    = wq_head ? m1_w_data : m0_w_data;
  assign s_w_strb    = wq_head ? m1_w_strb : m0_w_strb;
  assign s_w_last    = wq_head ? m1_w_last : m0_w_last;
  assign m0_w_ready  = wq_head_vld && !wq_head && s_w_ready;
  assign m1_w_ready  = wq_head_vld && wq_head && s_w_ready;
  assign w_pop       = s_w_valid && s_w_ready && s_w_last;
  assign aw_hold     = wq_full && !w_pop;
  assign aw_push     = aw_m0_rdy || aw_m1_rdy;

  always_comb begin
    wq_d     = wq_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wq_cnt_d = wq_cnt_q;
    if (aw_push) begin
      wq_d[wr_ptr_q] = aw_m1_rdy;
      wr_ptr_d       = wr_ptr_q + PW'(1);
    end
    if (w_pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({aw_push, w_pop})
      2'b10:   wq_cnt_d = wq_cnt_q + (PW+1)'(1);
      2'b01:   wq_cnt_d = wq_cnt_q - (PW+1)'(1);
      default: wq_cnt_d = wq_cnt_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wq_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wq_cnt_q <= '0;
    end else begin
      wq_q     <= wq_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wq_cnt_q <= wq_cnt_d;
    end
  end

  assign m0_r_valid = reset_n && s_r_valid && !s_r_id[ID_W];
  assign m1_r_valid = reset_n && s_r_valid && s_r_id[ID_W];
  assign s_r_ready  = s_r_id[ID_W] ? m1_r_ready : m0_r_ready;
  assign m0_r_id    = s_r_id[ID_W-1:0];
  assign m1_r_id    = s_r_id[ID_W-1:0];
  assign m0_r_data  = s_r_data;
  assign m1_r_data  = s_r_data;
  assign m0_r_resp  = s_r_resp;
  assign m1_r_resp  = s_r_resp;
  assign m0_r_last  = s_r_last;
  assign m1_r_last  = s_r_last;

  assign m0_b_valid = reset_n && s_b_valid && !s_b_id[ID_W];
  assign m1_b_valid = reset_n && s_b_valid && s_b_id[ID_W];
  assign s_b_ready  = s_b_id[ID_W] ? m1_b_ready : m0_b_ready;
  assign m0_b_id    = s_b_id[ID_W-1:0];
  assign m1_b_id    = s_b_id[ID_W-1:0];
  assign m0_b_resp  = s_b_resp;
  assign m1_b_resp  = s_b_resp;
endmodule
